// File: rtl/hazard_pkg.sv
// Shared types for the load-use / halt hazard unit: FSM states, scoreboard entry
// layout and the default halt opcode.
package hazard_pkg;

  localparam logic [3:0] HLT_OP_DEF = 4'b1111;

  // Scoreboard dst field is sized for the widest register file in use; REG_W must not exceed it.
  localparam int SB_DST_MAX_W = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [SB_DST_MAX_W-1:0] dst;
  } sb_entry_t;

endpackage

// File: rtl/load_scoreboard.sv
// Shift-register scoreboard of loads still in flight after leaving ID; flags a hit
// when an ID source operand names a destination that is not yet available.
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W       = 4,
  parameter int LOAD_LAT    = 1,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REG_W-1:0] push_dst,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             rs_used,
  input  logic             rt_used,
  output logic             hit
);

  sb_entry_t sb_q [LOAD_LAT];

  // NOTE: the whole array is reset; it is tiny and clearing dst too keeps stale
  // indices out of waveforms, though only the valid bits matter for correctness.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LOAD_LAT; k++) sb_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every entry move one slot per clock
      // regardless of statement order; blocking here would collapse the shift.
      sb_q[0] <= '{valid: push, dst: SB_DST_MAX_W'(push_dst)};
      for (int k = 1; k < LOAD_LAT; k++) sb_q[k] <= sb_q[k-1];
    end
  end

  // NOTE: hit gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (sb_q[k].valid && !(ZERO_REG_EN && (sb_q[k].dst == '0)) &&
          ((rs_used && (sb_q[k].dst == SB_DST_MAX_W'(rs))) ||
           (rt_used && (sb_q[k].dst == SB_DST_MAX_W'(rt))))) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit_sb.sv
// Load-use and halt hazard unit: scoreboard-based stall detection, halt drain FSM,
// branch-flush priority mux and a saturating load-use stall counter.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int              REG_W       = 4,
  parameter int              OP_W        = 4,
  parameter logic [OP_W-1:0] HLT_OP      = HLT_OP_DEF,
  parameter int              LOAD_LAT    = 1,
  parameter int              DRAIN_CYC   = 3,
  parameter bit              ZERO_REG_EN = 1'b1,
  parameter int              CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OP_W-1:0]  id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_is_load,
  input  logic [REG_W-1:0] id_ld_dst,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             stall,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e          state_q, state_d;
  logic [DC_W-1:0] drain_q, drain_d;
  logic            hlt_in_id;
  logic            sb_hit;
  logic            lu;
  logic            sel_lu;
  logic            sb_push;

  assign hlt_in_id = id_valid && (id_opcode == HLT_OP);
  assign lu        = id_valid && sb_hit;
  // A stalled or flushed load never reaches EX, so it must not enter the scoreboard.
  assign sb_push   = id_valid && id_is_load && !stall;

  load_scoreboard #(
    .REG_W      (REG_W),
    .LOAD_LAT   (LOAD_LAT),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_load_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .push    (sb_push),
    .push_dst(id_ld_dst),
    .rs      (id_rs),
    .rt      (id_rt),
    .rs_used (id_rs_used),
    .rt_used (id_rt_used),
    .hit     (sb_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (hlt_in_id && !ex_branch_taken) begin
          state_d = DRAIN;
          drain_d = DC_W'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        // A taken branch while draining means the HLT was fetched down the wrong path.
        if (ex_branch_taken)     state_d = RUN;
        else if (drain_q == '0)  state_d = HALTED;
        else                     drain_d = drain_q - 1'b1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    sel_lu      = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall       = 1'b1;
    end else if (ex_branch_taken && (state_q != HALTED)) begin
      flush = 1'b1;
      stall = 1'b1;
    end else if ((state_q != RUN) || hlt_in_id) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall       = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall       = 1'b1;
      sel_lu      = 1'b1;
    end
  end

  assign halted = (state_q == HALTED) && !rst;

  always_ff @(posedge clk) begin
    if (rst)                             stall_cnt <= '0;
    else if (sel_lu && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed scoreboard bench for hazard_unit_sb: three instances (LOAD_LAT=1 with a
// 4-bit counter, LOAD_LAT=3, zero-register exemption off) share one stimulus stream.
module tb_hazard_unit_sb;

  localparam logic [3:0] C_RUN = 4'b1100;  // {pc_write, if_id_write, stall, flush}
  localparam logic [3:0] C_STL = 4'b0010;
  localparam logic [3:0] C_FLS = 4'b1111;
  localparam logic [3:0] HLT   = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_rs_used, id_rt_used, id_is_load, ex_branch_taken;
  logic [3:0] id_opcode, id_rs, id_rt, id_ld_dst;

  logic        pcw [3];
  logic        ifw [3];
  logic        stl [3];
  logic        fls [3];
  logic        hlt [3];
  logic [3:0]  cnt_d1;
  logic [15:0] cnt_d3, cnt_dz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         dut;
    string      tag;
    logic [3:0] ctl;
    logic       halted;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_unit_sb #(.LOAD_LAT(1), .CNT_W(4)) d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_load(id_is_load),
    .id_ld_dst(id_ld_dst), .ex_branch_taken(ex_branch_taken), .pc_write(pcw[0]),
    .if_id_write(ifw[0]), .stall(stl[0]), .flush(fls[0]), .halted(hlt[0]), .stall_cnt(cnt_d1)
  );

  hazard_unit_sb #(.LOAD_LAT(3)) d3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_load(id_is_load),
    .id_ld_dst(id_ld_dst), .ex_branch_taken(ex_branch_taken), .pc_write(pcw[1]),
    .if_id_write(ifw[1]), .stall(stl[1]), .flush(fls[1]), .halted(hlt[1]), .stall_cnt(cnt_d3)
  );

  hazard_unit_sb #(.LOAD_LAT(1), .ZERO_REG_EN(1'b0)) dz (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_load(id_is_load),
    .id_ld_dst(id_ld_dst), .ex_branch_taken(ex_branch_taken), .pc_write(pcw[2]),
    .if_id_write(ifw[2]), .stall(stl[2]), .flush(fls[2]), .halted(hlt[2]), .stall_cnt(cnt_dz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rs,
                       input logic rsu, input logic [3:0] rt, input logic rtu,
                       input logic ld, input logic [3:0] dst, input logic br);
    id_valid        = v;
    id_opcode       = op;
    id_rs           = rs;
    id_rs_used      = rsu;
    id_rt           = rt;
    id_rt_used      = rtu;
    id_is_load      = ld;
    id_ld_dst       = dst;
    ex_branch_taken = br;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic push_exp(input int dut, input string tag, input logic [3:0] ctl,
                          input logic halted, input int cnt);
    exp_t e;
    e.dut    = dut;
    e.tag    = tag;
    e.ctl    = ctl;
    e.halted = halted;
    e.cnt    = cnt;
    exp_q.push_back(e);
  endtask

  // Compare every pending expectation mid-cycle, then advance one clock.
  task automatic tick();
    exp_t        e;
    logic [31:0] cnt_obs;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0:       cnt_obs = 32'(cnt_d1);
        1:       cnt_obs = 32'(cnt_d3);
        default: cnt_obs = 32'(cnt_dz);
      endcase
      check($sformatf("%s[d%0d].ctl", e.tag, e.dut),
            32'({pcw[e.dut], ifw[e.dut], stl[e.dut], fls[e.dut]}), 32'(e.ctl));
      check($sformatf("%s[d%0d].halted", e.tag, e.dut), 32'(hlt[e.dut]), 32'(e.halted));
      check($sformatf("%s[d%0d].cnt", e.tag, e.dut), cnt_obs, e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) push_exp(d, "reset", C_STL, 1'b0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    idle();

    // Classic single-bubble load-use (LOAD_LAT=1), also seen by the 3-deep scoreboard.
    reset_all();
    drive(1, 0, 1, 1, 2, 1, 1, 5, 0);
    push_exp(0, "ld5", C_RUN, 0, 0); push_exp(1, "ld5", C_RUN, 0, 0);
    tick();
    drive(1, 0, 5, 1, 2, 1, 0, 0, 0);
    push_exp(0, "use5a", C_STL, 0, 0); push_exp(1, "use5a", C_STL, 0, 0);
    push_exp(2, "use5a", C_STL, 0, 0);
    tick();
    push_exp(0, "use5b", C_RUN, 0, 1); push_exp(1, "use5b", C_STL, 0, 1);
    push_exp(2, "use5b", C_RUN, 0, 1);
    tick();
    idle();
    push_exp(0, "post5", C_RUN, 0, 1);
    tick();

    // LOAD_LAT=3: three consecutive stalls on an rt dependency.
    reset_all();
    drive(1, 0, 1, 1, 2, 1, 1, 7, 0);
    push_exp(1, "ld7", C_RUN, 0, 0);
    tick();
    drive(1, 0, 1, 1, 7, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push_exp(1, $sformatf("use7_%0d", i), (i < 3) ? C_STL : C_RUN, 0, i);
      push_exp(0, $sformatf("use7_%0d", i), (i == 0) ? C_STL : C_RUN, 0, (i == 0) ? 0 : 1);
      tick();
    end

    // Same dependency but rt not read: no stall.
    reset_all();
    drive(1, 0, 1, 1, 2, 1, 1, 7, 0);
    push_exp(1, "ld7n", C_RUN, 0, 0);
    tick();
    drive(1, 0, 1, 1, 7, 0, 0, 0, 0);
    push_exp(1, "rt_unused_a", C_RUN, 0, 0);
    tick();
    push_exp(1, "rt_unused_b", C_RUN, 0, 0);
    tick();

    // Register 0: exempt when ZERO_REG_EN=1, a normal hazard when 0.
    reset_all();
    drive(1, 0, 1, 1, 2, 1, 1, 0, 0);
    push_exp(0, "ld0", C_RUN, 0, 0); push_exp(2, "ld0", C_RUN, 0, 0);
    tick();
    drive(1, 0, 0, 1, 2, 1, 0, 0, 0);
    push_exp(0, "use0a", C_RUN, 0, 0); push_exp(2, "use0a", C_STL, 0, 0);
    tick();
    push_exp(0, "use0b", C_RUN, 0, 0); push_exp(2, "use0b", C_RUN, 0, 1);
    tick();

    // Halt: three drain cycles, then terminal HALTED (branches ignored) until reset.
    reset_all();
    drive(1, HLT, 0, 0, 0, 0, 0, 0, 0);
    push_exp(0, "hlt_id", C_STL, 0, 0);
    tick();
    idle();
    for (int i = 1; i <= 5; i++) begin
      push_exp(0, $sformatf("drain_%0d", i), C_STL, (i >= 4) ? 1'b1 : 1'b0, 0);
      tick();
    end
    drive(1, 0, 1, 1, 2, 1, 1, 3, 1);
    push_exp(0, "halted_br", C_STL, 1, 0);
    tick();
    reset_all();
    idle();
    push_exp(0, "post_halt", C_RUN, 0, 0);
    tick();

    // Wrong-path halt: branch in the first drain cycle returns to RUN with a flush.
    reset_all();
    drive(1, HLT, 0, 0, 0, 0, 0, 0, 0);
    push_exp(0, "wp_hlt", C_STL, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    push_exp(0, "wp_br", C_FLS, 0, 0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      push_exp(0, $sformatf("wp_run_%0d", i), C_RUN, 0, 0);
      tick();
    end
    drive(1, HLT, 0, 0, 0, 0, 0, 0, 1);
    push_exp(0, "hlt_br_same", C_FLS, 0, 0);
    tick();
    idle();
    push_exp(0, "hlt_br_after", C_RUN, 0, 0);
    tick();

    // Branch outranks load-use (no count), and a flushed load is never recorded.
    reset_all();
    drive(1, 0, 1, 1, 2, 1, 1, 5, 0);
    push_exp(0, "lub_ld", C_RUN, 0, 0);
    tick();
    drive(1, 0, 5, 1, 2, 1, 0, 0, 1);
    push_exp(0, "lub_br", C_FLS, 0, 0);
    tick();
    idle();
    push_exp(0, "lub_after", C_RUN, 0, 0);
    tick();
    drive(1, 0, 1, 1, 2, 1, 1, 6, 1);
    push_exp(0, "sq_ld", C_FLS, 0, 0);
    tick();
    drive(1, 0, 6, 1, 2, 1, 0, 0, 0);
    push_exp(0, "sq_use", C_RUN, 0, 0);
    tick();

    // Saturation of the 4-bit counter: 17 load-use stalls leave it at 15.
    reset_all();
    exp_cnt = 0;
    drive(1, 0, 3, 1, 0, 0, 1, 3, 0);
    for (int i = 0; i < 17; i++) begin
      push_exp(0, $sformatf("sat_iss_%0d", i), C_RUN, 0, exp_cnt);
      tick();
      push_exp(0, $sformatf("sat_stl_%0d", i), C_STL, 0, exp_cnt);
      tick();
      if (exp_cnt < 15) exp_cnt++;
    end
    idle();
    push_exp(0, "sat_final", C_RUN, 0, 15);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Parametrised load-use and halt hazard unit for the in-order pipeline; sits between decode and the IF/ID and ID/EX pipeline registers.
- Generalises the single-stage load-use check into a shift-register scoreboard of in-flight loads, so the load latency is configurable.
- Adds operand-use qualification, a zero-register exemption and branch-flush priority.
- Adds a halt drain state machine and a saturating load-use stall counter.

Parameters:
- REG_W, 4, register-index width
- OP_W, 4, opcode width
- HLT_OP, 4'b1111, halt opcode
- LOAD_LAT, 1, cycles a load result is unavailable after leaving ID (>=1)
- DRAIN_CYC, 3, cycles to drain older instructions before halted asserts (>=1)
- ZERO_REG_EN, 1, when 1, register 0 never causes a hazard
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  OP_W  opcode in ID
- id_rs  in  REG_W  source 1 index
- id_rt  in  REG_W  source 2 index
- id_rs_used  in  1  source 1 is read
- id_rt_used  in  1  source 2 is read
- id_is_load  in  1  ID instruction is a load
- id_ld_dst  in  REG_W  load destination index
- ex_branch_taken  in  1  taken branch resolved in EX this cycle
- pc_write  out  1  PC enable
- if_id_write  out  1  IF/ID enable
- stall  out  1  insert bubble into ID/EX
- flush  out  1  squash IF/ID contents
- halted  out  1  processor halted
- stall_cnt  out  CNT_W  load-use stall cycles since reset

Behaviour:
- Outputs pc_write/if_id_write/stall/flush are combinational from state and inputs. Scoreboard, FSM and stall_cnt are registered.
- Reset: while rst=1, outputs are pc_write=0, if_id_write=0, stall=1, flush=0 and halted=0. The scoreboard entries clear invalid, FSM goes to RUN and stall_cnt goes to 0. Reset mid-halt or mid-drain returns to RUN.
- Scoreboard: LOAD_LAT entries {valid, dst}. Entry k is a load k+1 cycles past ID.
  - Every cycle entry k+1 takes entry k.
  - Entry 0 takes {id_valid & id_is_load & issue, id_ld_dst}, where issue = no stall and no flush.
  - A bubble shifts in invalid.
- Load-use hazard (lu): any valid entry whose dst equals id_rs with id_rs_used, or equals id_rt with id_rt_used, with id_valid=1. A dst of 0 is excluded when ZERO_REG_EN=1.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when id_valid & id_opcode==HLT_OP & ~ex_branch_taken; a drain counter loads DRAIN_CYC-1.
  - DRAIN decrements the counter; at 0 it moves to HALTED.
  - In DRAIN, ex_branch_taken means the HLT was on the wrong path: return to RUN and assert flush that cycle.
  - HALTED is terminal until rst.
- Output priority (highest first):
  1. ex_branch_taken: flush=1, stall=1, pc_write=1, if_id_write=1. This applies in RUN or DRAIN.
  2. DRAIN/HALTED, or HLT detected in ID in RUN: pc_write=0, if_id_write=0, stall=1.
  3. lu: pc_write=0, if_id_write=0, stall=1.
  4. Otherwise: pc_write=1, if_id_write=1, stall=0, flush=0.
- halted=1 only in HALTED.
- stall_cnt increments only on cycles where case 3 is selected. It saturates at all-ones and never wraps.
- A load and a flush in the same cycle: the load is not entered, since it is squashed.
- With LOAD_LAT=1 behaviour equals the classic single-bubble load-use stall.

Decomposition:
- Shared package hazard_pkg:
  - HLT_OP default
  - state enum {RUN, DRAIN, HALTED}
  - scoreboard entry struct {valid, dst}
- One sub-module, load_scoreboard (params REG_W, LOAD_LAT, ZERO_REG_EN).
  - Inputs: clk, rst, push, push_dst, rs/rt and their used flags.
  - Output: hit.
- The FSM, priority mux and counter stay in the top level.

Test Plan:
- LOAD_LAT=1: load dst=5 issues, next ID reads rs=5 used -> exactly 1 cycle stall=1, pc_write=0; then proceeds; stall_cnt=1.
- LOAD_LAT=3: load dst=7, following instruction reads rt=7 -> 3 consecutive stall cycles, stall_cnt=3. The same case with rt_used=0 gives no stall.
- ZERO_REG_EN=1: load dst=0, next reads rs=0 -> no stall. With ZERO_REG_EN=0 -> 1 stall.
- HLT in ID, DRAIN_CYC=3 -> pc_write=0 from that cycle; halted=1 on cycle 4 and stays until rst. rst then gives RUN with halted=0 and stall_cnt=0.
- HLT in ID and ex_branch_taken=1 in the first DRAIN cycle -> flush=1, pc_write=1, FSM in RUN, halted never asserts.
- Load-use hazard coincident with ex_branch_taken -> flush=1, stall_cnt unchanged. Force 2^CNT_W-1 load-use stalls plus one more -> stall_cnt stays at all-ones.
